dbg_cmd_bridge: RTL

//  Byte-stream front end for dbg_module: assembles 9-byte command frames from an RX byte

---
 rtl/dbg_pkg.sv | 52 +++++
 rtl/dbg_cmd_bridge.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug command bridge.
//  - command codes understood by dbg_module
//  - response status codes
//  - frame geometry and bridge state encoding
//  - helper that picks the next outgoing response byte
package dbg_pkg;

   localparam logic [7:0] CMD_NOP        = 8'h00;
   localparam logic [7:0] CMD_RD_MEM     = 8'h01;
   localparam logic [7:0] CMD_WR_MEM     = 8'h02;
   localparam logic [7:0] CMD_HALT       = 8'h03;
   localparam logic [7:0] CMD_RESUME     = 8'h04;
   localparam logic [7:0] CMD_RST_CORE   = 8'h05;
   localparam logic [7:0] CMD_RST_PERIPH = 8'h06;
   localparam logic [7:0] CMD_RST_ALL    = 8'h07;
   localparam logic [7:0] CMD_RD_REG     = 8'h10;
   localparam logic [7:0] CMD_WR_REG     = 8'h20;

   localparam logic [7:0] ST_OK          = 8'h00;
   localparam logic [7:0] ST_TIMEOUT     = 8'hEE;

   localparam int         FRAME_BYTES    = 9;

   // Index of the status byte in the response sequence; 0..3 are data bytes.
   localparam logic [2:0] TX_STATUS_IDX  = 3'd4;

   typedef enum logic [1:0] {
      S_RECV = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_e;

   // Only reads return a data word ahead of the status byte.
   function automatic logic resp_has_data(input logic [7:0] cmd);
      return (cmd == CMD_RD_MEM) || (cmd == CMD_RD_REG);
   endfunction

   function automatic logic [7:0] resp_byte(input logic [31:0] word,
                                            input logic [2:0]  idx,
                                            input logic [7:0]  status);
      logic [7:0] b;
      case (idx)
         3'd0:    b = word[7:0];
         3'd1:    b = word[15:8];
         3'd2:    b = word[23:16];
         3'd3:    b = word[31:24];
         default: b = status;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/dbg_cmd_bridge.sv
// Byte-stream front end for dbg_module. Collects 9-byte command frames
// (cmd, addr LSB first, data LSB first), drives them into dbg_module, waits
// for completion (or times out) and streams the response back.
//
// Ports
//  clk           system clock
//  rstn_i        asynchronous active-low reset
//  rx_data_i     incoming byte, accepted on rx_valid_i & rx_ready_o
//  rx_valid_i    incoming byte valid
//  rx_ready_o    bridge can take a byte (only while collecting a frame)
//  tx_data_o     outgoing response byte, stable while tx_valid_o & !tx_ready_i
//  tx_valid_o    outgoing byte valid
//  tx_ready_i    sink takes the byte this cycle
//  dbg_cmd_o     command to dbg_module
//  dbg_addr_o    address to dbg_module
//  dbg_data_o    write data to dbg_module
//  dbg_data_i    read data from dbg_module
//  dbg_ready_i   dbg_module ready
//  busy_o        high unless idle with no partial frame
//
// state  | meaning
// S_RECV | collecting frame bytes; idle timer drops stale partial frames
// S_EXEC | command presented to dbg_module; waiting for ready or timeout
// S_RESP | streaming optional read data then the status byte
module dbg_cmd_bridge
   import dbg_pkg::*;
#(
   parameter int EXEC_TIMEOUT = 1024,
   parameter int RX_TIMEOUT   = 4096
) (
   input  logic        clk,
   input  logic        rstn_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic [7:0]  dbg_cmd_o,
   output logic [31:0] dbg_addr_o,
   output logic [31:0] dbg_data_o,
   input  logic [31:0] dbg_data_i,
   input  logic        dbg_ready_i,
   output logic        busy_o
);

   localparam int EW = $clog2(EXEC_TIMEOUT) + 1;
   localparam int RW = $clog2(RX_TIMEOUT) + 1;

   localparam logic [EW-1:0] EXEC_LAST = EW'(EXEC_TIMEOUT - 1);
   localparam logic [EW-1:0] EXEC_SAT  = EW'(EXEC_TIMEOUT);
   localparam logic [RW-1:0] RX_LAST   = RW'(RX_TIMEOUT - 1);
   localparam logic [RW-1:0] RX_SAT    = RW'(RX_TIMEOUT);
   localparam logic [3:0]    LAST_BYTE = 4'(FRAME_BYTES - 1);

   state_e         state_q,    state_d;
   logic [3:0]     cnt_q,      cnt_d;
   logic [7:0]     cmd_q,      cmd_d;
   logic [31:0]    addr_q,     addr_d;
   logic [31:0]    data_q,     data_d;
   logic [RW-1:0]  idle_q,     idle_d;
   logic [EW-1:0]  exec_q,     exec_d;
   logic           first_q,    first_d;
   logic [31:0]    resp_q,     resp_d;
   logic [7:0]     status_q,   status_d;
   logic [2:0]     tx_idx_q,   tx_idx_d;
   logic           tx_valid_q, tx_valid_d;
   logic [7:0]     tx_data_q,  tx_data_d;

   logic           rx_fire;
   logic           exec_done;
   logic           exec_to;

   assign rx_ready_o = (state_q == S_RECV);
   assign rx_fire    = rx_valid_i && rx_ready_o;

   // Ready in cycle 0 is the leftover idle ready from dbg_module, so it is
   // only taken as completion once the first cycle has passed.
   assign exec_done  = (state_q == S_EXEC) && first_q && dbg_ready_i;
   assign exec_to    = (state_q == S_EXEC) && (exec_q >= EXEC_LAST) && !exec_done;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      data_d     = data_q;
      idle_d     = idle_q;
      exec_d     = exec_q;
      first_d    = first_q;
      resp_d     = resp_q;
      status_d   = status_q;
      tx_idx_d   = tx_idx_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;

      case (state_q)
         S_RECV: begin
            first_d = 1'b0;
            exec_d  = '0;
            if (rx_fire) begin
               idle_d = '0;
               case (cnt_q)
                  4'd0:    cmd_d          = rx_data_i;
                  4'd1:    addr_d[7:0]    = rx_data_i;
                  4'd2:    addr_d[15:8]   = rx_data_i;
                  4'd3:    addr_d[23:16]  = rx_data_i;
                  4'd4:    addr_d[31:24]  = rx_data_i;
                  4'd5:    data_d[7:0]    = rx_data_i;
                  4'd6:    data_d[15:8]   = rx_data_i;
                  4'd7:    data_d[23:16]  = rx_data_i;
                  default: data_d[31:24]  = rx_data_i;
               endcase
               if (cnt_q == LAST_BYTE) begin
                  cnt_d   = 4'd0;
                  state_d = S_EXEC;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end else if (cnt_q != 4'd0) begin
               // Host went quiet mid-frame: drop the partial frame so the
               // next byte is treated as a fresh command.
               if (idle_q >= RX_LAST) begin
                  cnt_d  = 4'd0;
                  idle_d = '0;
               end else if (idle_q != RX_SAT) begin
                  idle_d = idle_q + 1'b1;
               end
            end else begin
               idle_d = '0;
            end
         end

         S_EXEC: begin
            first_d = 1'b1;
            if (exec_q != EXEC_SAT) begin
               exec_d = exec_q + 1'b1;
            end
            if (exec_done) begin
               resp_d     = dbg_data_i;
               status_d   = ST_OK;
               state_d    = S_RESP;
               tx_valid_d = 1'b1;
               if (resp_has_data(cmd_q)) begin
                  tx_idx_d  = 3'd0;
                  tx_data_d = dbg_data_i[7:0];
               end else begin
                  tx_idx_d  = TX_STATUS_IDX;
                  tx_data_d = ST_OK;
               end
            end else if (exec_to) begin
               status_d   = ST_TIMEOUT;
               state_d    = S_RESP;
               tx_valid_d = 1'b1;
               tx_idx_d   = TX_STATUS_IDX;
               tx_data_d  = ST_TIMEOUT;
            end
         end

         S_RESP: begin
            if (tx_valid_q && tx_ready_i) begin
               if (tx_idx_q == TX_STATUS_IDX) begin
                  tx_valid_d = 1'b0;
                  state_d    = S_RECV;
                  cnt_d      = 4'd0;
               end else begin
                  tx_idx_d  = tx_idx_q + 3'd1;
                  tx_data_d = resp_byte(resp_q, tx_idx_q + 3'd1, status_q);
               end
            end
         end

         default: begin
            state_d    = S_RECV;
            cnt_d      = 4'd0;
            tx_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= S_RECV;
         cnt_q      <= 4'd0;
         cmd_q      <= CMD_NOP;
         addr_q     <= '0;
         data_q     <= '0;
         idle_q     <= '0;
         exec_q     <= '0;
         first_q    <= 1'b0;
         resp_q     <= '0;
         status_q   <= ST_OK;
         tx_idx_q   <= 3'd0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         idle_q     <= idle_d;
         exec_q     <= exec_d;
         first_q    <= first_d;
         resp_q     <= resp_d;
         status_q   <= status_d;
         tx_idx_q   <= tx_idx_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // Dropping the command as soon as ready returns keeps dbg_module from
   // seeing the same command again on the completion cycle.
   always_comb begin
      dbg_cmd_o = CMD_NOP;
      if ((state_q == S_EXEC) && !(dbg_ready_i && first_q)) begin
         dbg_cmd_o = cmd_q;
      end
   end

   assign dbg_addr_o = addr_q;
   assign dbg_data_o = data_q;
   assign tx_valid_o = tx_valid_q;
   assign tx_data_o  = tx_data_q;
   assign busy_o     = !((state_q == S_RECV) && (cnt_q == 4'd0));

endmodule
